// File: rtl/wb_control_pkg.sv
// Shared definitions for the Wishbone control / signature-dump block.
// Register offsets, STATUS bit positions, FSM encoding and a byte-lane helper.
package wb_control_pkg;

    localparam logic [1:0] REG_SIG_BEGIN = 2'd0;
    localparam logic [1:0] REG_SIG_END   = 2'd1;
    localparam logic [1:0] REG_STOP      = 2'd2;
    localparam logic [1:0] REG_RSVD      = 2'd3;

    localparam int STAT_HALT = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OOB  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Merge new data into an old word, byte lane n taken when sel[n] is set.
    function automatic logic [31:0] apply_sel(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_control_unit_if.sv
// Wishbone slave-side bus bundle for the control unit.
// Read data stays a plain port on the unit since it is a tri-stated bus net.
interface wb_control_unit_if;

    logic        stb_i;
    logic        cyc_i;
    logic [31:0] adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic        we_i;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;

    modport master (
        output stb_i, cyc_i, adr_i, sel_i, dat_i, we_i,
        input  ack_o, err_o, rty_o
    );

    modport slave (
        input  stb_i, cyc_i, adr_i, sel_i, dat_i, we_i,
        output ack_o, err_o, rty_o
    );

endinterface

// File: rtl/wb_control_unit.sv
// Wishbone-mapped test controller: SIG_BEGIN/SIG_END/STOP registers and a
// sequencer that streams the signature region out of RAM after STOP.
module wb_control_unit
    import wb_control_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS        = 32'h3000_0000,
    parameter logic [31:0] MEMORY_BASE_ADDRESS = 32'h2000_0000,
    parameter logic [31:0] MEMORY_SIZE         = 32'h4000
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    wb_control_unit_if.slave                    wb,
    output wire  [31:0]                         dat_o,
    output logic [$clog2(MEMORY_SIZE/4)-1:0]    mem_adr_o,
    input  logic [31:0]                         mem_dat_i,
    output logic                                sig_valid_o,
    output logic [31:0]                         sig_data_o,
    output logic                                halt_o,
    output logic                                done_o
);

    localparam int AW = $clog2(MEMORY_SIZE / 4);

    state_e      state_q, state_d;
    logic        ack_q;
    logic        halt_q, halt_d;
    logic        oob_q, oob_d;
    logic [31:0] begin_q, begin_d;
    logic [31:0] endr_q, endr_d;
    logic [31:0] ptr_q, ptr_d;
    logic [31:0] lim_q, lim_d;

    logic        sel_hit;
    logic        wr_commit;
    logic [1:0]  reg_idx;
    logic        in_dump;
    logic [31:0] offset;
    logic        oob_word;
    logic [31:0] start_ptr;
    logic [31:0] start_lim;
    logic [31:0] status;
    logic [31:0] rdata;
    logic        unused_adr;

    assign sel_hit = wb.stb_i & wb.cyc_i
                   & (wb.adr_i[31:4] == BASE_ADDRESS[31:4]);
    assign reg_idx    = wb.adr_i[3:2];
    assign unused_adr = ^wb.adr_i[1:0];

    // Writes commit at the end of the ack cycle, so a STOP starts the dump
    // in the cycle right after its acknowledge.
    assign wr_commit = ack_q & sel_hit & wb.we_i;

    assign in_dump   = (state_q == ST_DUMP);
    assign offset    = ptr_q - MEMORY_BASE_ADDRESS;
    assign oob_word  = (offset >= MEMORY_SIZE);
    assign start_ptr = {begin_q[31:2], 2'b00};
    assign start_lim = {endr_q[31:2], 2'b00};

    // Ack pulses one cycle after select; a held select re-acks every other cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ack_q <= 1'b0;
        else       ack_q <= sel_hit & ~ack_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            halt_q  <= 1'b0;
            oob_q   <= 1'b0;
            begin_q <= '0;
            endr_q  <= '0;
            ptr_q   <= '0;
            lim_q   <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            oob_q   <= oob_d;
            begin_q <= begin_d;
            endr_q  <= endr_d;
            ptr_q   <= ptr_d;
            lim_q   <= lim_d;
        end
    end

    // Next-state: dump sequencing plus register writes from the bus.
    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        oob_d   = oob_q;
        begin_d = begin_q;
        endr_d  = endr_q;
        ptr_d   = ptr_q;
        lim_d   = lim_q;

        if (in_dump) begin
            ptr_d = ptr_q + 32'd4;
            if (oob_word) oob_d = 1'b1;
            if (({1'b0, ptr_q} + 33'd4) >= {1'b0, lim_q}) begin
                state_d = ST_DONE;
            end
        end

        if (wr_commit) begin
            case (reg_idx)
                REG_SIG_BEGIN: begin_d = apply_sel(begin_q, wb.dat_i, wb.sel_i);
                REG_SIG_END:   endr_d  = apply_sel(endr_q, wb.dat_i, wb.sel_i);
                REG_STOP: begin
                    if (state_q == ST_IDLE) begin
                        halt_d  = 1'b1;
                        ptr_d   = start_ptr;
                        lim_d   = start_lim;
                        state_d = (start_ptr >= start_lim) ? ST_DONE : ST_DUMP;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register read mux, driven onto the shared bus only while acking.
    always_comb begin
        status            = '0;
        status[STAT_HALT] = halt_q;
        status[STAT_DONE] = (state_q == ST_DONE);
        status[STAT_OOB]  = oob_q;
        case (reg_idx)
            REG_SIG_BEGIN: rdata = begin_q;
            REG_SIG_END:   rdata = endr_q;
            REG_STOP:      rdata = status;
            default:       rdata = '0;
        endcase
    end

    assign dat_o    = ack_q ? rdata : 32'hzzzz_zzzz;
    assign wb.ack_o = ack_q;
    assign wb.err_o = 1'b0;
    assign wb.rty_o = 1'b0;

    assign mem_adr_o   = in_dump ? offset[AW+1:2] : '0;
    assign sig_valid_o = in_dump;
    assign sig_data_o  = (in_dump & ~oob_word) ? mem_dat_i : 32'd0;
    assign halt_o      = halt_q;
    assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_wb_control_unit.sv
// Directed bench for wb_control_unit: bus tasks, RAM model and a
// scoreboard queue of expected signature words checked by a monitor.
module tb_wb_control_unit;
    import wb_control_pkg::*;

    localparam logic [31:0] CTRL = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    wb_control_unit_if bus ();
    wire  [31:0] dat_o;
    logic [11:0] mem_adr;
    logic [31:0] mem_dat;
    logic        sig_valid;
    logic [31:0] sig_data;
    logic        halt;
    logic        done;

    logic [31:0] ram [0:4095];
    logic [31:0] exp_q [$];
    int          n_chk  = 0;
    int          n_fail = 0;

    assign mem_dat = ram[mem_adr];

    always #5 clk = ~clk;

    wb_control_unit dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wb          (bus),
        .dat_o       (dat_o),
        .mem_adr_o   (mem_adr),
        .mem_dat_i   (mem_dat),
        .sig_valid_o (sig_valid),
        .sig_data_o  (sig_data),
        .halt_o      (halt),
        .done_o      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every valid signature word must match the queue head.
    always @(negedge clk) begin
        if (!rst && sig_valid) begin
            if (exp_q.size() == 0) chk("sig_unexpected", {31'b0, sig_valid}, 32'd0);
            else                   chk("sig_data", sig_data, exp_q.pop_front());
        end
    end

    task automatic bus_idle();
        bus.stb_i = 1'b0;
        bus.cyc_i = 1'b0;
        bus.we_i  = 1'b0;
        bus.adr_i = '0;
        bus.sel_i = '0;
        bus.dat_i = '0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] data,
                            input logic [3:0] sel, input string tag);
        @(negedge clk);
        bus.stb_i = 1'b1;
        bus.cyc_i = 1'b1;
        bus.we_i  = 1'b1;
        bus.adr_i = adr;
        bus.sel_i = sel;
        bus.dat_i = data;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_ack"}, {31'b0, bus.ack_o}, 32'd1);
        @(posedge clk);
        #1 bus_idle();
    endtask

    task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp,
                           input string tag);
        @(negedge clk);
        bus.stb_i = 1'b1;
        bus.cyc_i = 1'b1;
        bus.we_i  = 1'b0;
        bus.adr_i = adr;
        bus.sel_i = 4'hF;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_ack"}, {31'b0, bus.ack_o}, 32'd1);
        chk(tag, dat_o, exp);
        @(posedge clk);
        #1 bus_idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_idle();
        exp_q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        #1 chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'h5A00_0000 ^ 32'(i);
        ram[4]       = 32'd1;
        ram[5]       = 32'd2;
        ram[6]       = 32'd3;
        ram[7]       = 32'd4;
        ram[12'hFFF] = 32'hCAFE_F00D;
        bus_idle();

        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ack",   {31'b0, bus.ack_o}, 32'd0);
        chk("rst_halt",  {31'b0, halt}, 32'd0);
        chk("rst_done",  {31'b0, done}, 32'd0);
        chk("rst_valid", {31'b0, sig_valid}, 32'd0);
        chk("rst_madr",  {20'b0, mem_adr}, 32'd0);
        chk("rst_sdata", sig_data, 32'd0);
        chk("rst_err",   {30'b0, bus.err_o, bus.rty_o}, 32'd0);
        #1 rst = 1'b0;

        // Byte-lane write onto a cleared register.
        wb_write(CTRL + 0, 32'hAABB_CCDD, 4'b0101, "sel_wr");
        wb_read(CTRL + 0, 32'h00BB_00DD, "sel_rd");
        wb_write(CTRL + 0, 32'h1122_3344, 4'b1000, "sel_wr2");
        wb_read(CTRL + 0, 32'h11BB_00DD, "sel_rd2");

        // Held select: ack every other cycle, reserved reads 0.
        @(negedge clk);
        bus.stb_i = 1'b1;
        bus.cyc_i = 1'b1;
        bus.adr_i = CTRL + 12;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("held_ack", {31'b0, bus.ack_o}, (i == 1) ? 32'd0 : 32'd1);
            if (i != 1) chk("rsvd_rd", dat_o, 32'd0);
        end
        @(posedge clk);
        #1 bus_idle();

        // Main dump of four words.
        wb_write(CTRL + 0, 32'h2000_0010, 4'hF, "beg_wr");
        wb_write(CTRL + 4, 32'h2000_0020, 4'hF, "end_wr");
        wb_read(CTRL + 4, 32'h2000_0020, "end_rd");
        wb_read(CTRL + 8, 32'd0, "stat_idle");
        for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
        wb_write(CTRL + 8, 32'h0, 4'hF, "stop");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("dump_valid", {31'b0, sig_valid}, 32'd1);
        end
        @(negedge clk);
        chk("post_valid", {31'b0, sig_valid}, 32'd0);
        chk("post_done",  {31'b0, done}, 32'd1);
        chk("post_halt",  {31'b0, halt}, 32'd1);
        chk("post_sdata", sig_data, 32'd0);
        drain("dump4_drain");
        wb_read(CTRL + 8, 32'h3, "stat_done");

        // STOP ignored in DONE; register writes still stored.
        wb_write(CTRL + 8, 32'hFFFF_FFFF, 4'h0, "stop_again");
        wb_write(CTRL + 0, 32'h2000_0100, 4'hF, "beg_done");
        wb_read(CTRL + 0, 32'h2000_0100, "beg_done_rd");
        wb_read(CTRL + 8, 32'h3, "stat_still");

        // Unselected address gets no ack.
        do_reset();
        @(negedge clk);
        bus.stb_i = 1'b1;
        bus.cyc_i = 1'b1;
        bus.adr_i = 32'h2000_0000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("nosel_ack", {31'b0, bus.ack_o}, 32'd0);
        end
        #1 bus_idle();

        // Empty region: straight to DONE, nothing emitted.
        wb_write(CTRL + 0, 32'h2000_0000, 4'hF, "emp_beg");
        wb_write(CTRL + 4, 32'h2000_0000, 4'hF, "emp_end");
        wb_write(CTRL + 8, 32'h0, 4'h0, "emp_stop");
        @(negedge clk);
        chk("emp_valid", {31'b0, sig_valid}, 32'd0);
        chk("emp_done",  {31'b0, done}, 32'd1);

        // Region straddling the RAM top.
        do_reset();
        wb_write(CTRL + 0, 32'h2000_3FFC, 4'hF, "top_beg");
        wb_write(CTRL + 4, 32'h2000_4004, 4'hF, "top_end");
        exp_q.push_back(32'hCAFE_F00D);
        exp_q.push_back(32'h0);
        wb_write(CTRL + 8, 32'h0, 4'hF, "top_stop");
        @(negedge clk);
        chk("top_madr",   {20'b0, mem_adr}, 32'h0000_0FFF);
        chk("top_valid0", {31'b0, sig_valid}, 32'd1);
        @(negedge clk);
        chk("top_valid1", {31'b0, sig_valid}, 32'd1);
        @(negedge clk);
        chk("top_done", {31'b0, done}, 32'd1);
        drain("top_drain");
        wb_read(CTRL + 8, 32'h7, "stat_oob");

        // Reset in the middle of a long dump.
        do_reset();
        wb_write(CTRL + 0, 32'h2000_0000, 4'hF, "mid_beg");
        wb_write(CTRL + 4, 32'h2000_0040, 4'hF, "mid_end");
        for (int i = 0; i < 16; i++) exp_q.push_back(ram[i]);
        wb_write(CTRL + 8, 32'h0, 4'hF, "mid_stop");
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_valid", {31'b0, sig_valid}, 32'd0);
        chk("mid_halt",  {31'b0, halt}, 32'd0);
        chk("mid_madr",  {20'b0, mem_adr}, 32'd0);
        chk("mid_sdata", sig_data, 32'd0);
        chk("mid_seen",  32'(exp_q.size()), 32'd13);
        exp_q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        wb_read(CTRL + 8, 32'd0, "mid_stat");
        wb_read(CTRL + 0, 32'd0, "mid_beg_rd");

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_control_unit.md
WB_CONTROL_UNIT -- requirements
Module: wb_control

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h3000_0000, base of the 16-byte register window.
REQ-002 SHALL have parameter MEMORY_BASE_ADDRESS, default 32'h2000_0000, byte address of the data RAM.
REQ-003 SHALL have parameter MEMORY_SIZE, default 32'h4000, RAM size in bytes (power of two, multiple of 4).
REQ-004 clk_i  in  1  single clock; all logic rising-edge.
REQ-005 rst_i  in  1  reset; asynchronous, active-high.
REQ-006 stb_i, cyc_i  in  1 each  Wishbone strobe / cycle.
REQ-007 adr_i  in  32  Wishbone byte address.
REQ-008 sel_i  in  4  byte enables; bit n = dat_i[8n+7:8n].
REQ-009 dat_i  in  32  write data.
REQ-010 we_i  in  1  1 = write.
REQ-011 dat_o  out  32  read data; high-Z when ack_o=0 (shared bus net).
REQ-012 ack_o  out  1  transfer acknowledge.
REQ-013 err_o, rty_o  out  1 each  constant 0.
REQ-014 mem_adr_o  out  log2(MEMORY_SIZE/4)  RAM word index.
REQ-015 mem_dat_i  in  32  RAM word at mem_adr_o, combinational.
REQ-016 sig_valid_o  out  1  signature word valid this cycle.
REQ-017 sig_data_o  out  32  signature word.
REQ-018 halt_o  out  1  stop requested; test complete.
REQ-019 done_o  out  1  signature dump finished.

Function
REQ-020 Select = stb_i & cyc_i & (adr_i[31:4] == BASE_ADDRESS[31:4]).
REQ-021 ack_o SHALL rise the cycle after select and be a one-cycle pulse; a held select yields ack every other cycle.
REQ-022 Register map (offset adr_i[3:2]): 0 SIG_BEGIN RW, 1 SIG_END RW, 2 STOP (write-triggered, read = status), 3 reserved (reads 0, writes ignored).
REQ-023 SIG_BEGIN/SIG_END writes SHALL honour sel_i per byte; the write takes effect on the ack cycle.
REQ-024 STATUS read = {29'b0, oob, done_o, halt_o}; oob = any dumped word fell outside the RAM.
REQ-025 Any write to STOP (any sel_i, any data) in IDLE SHALL set halt_o and start the dump; STOP writes outside IDLE are acked and ignored.
REQ-026 FSM states IDLE -> DUMP -> DONE; DONE is held until reset.
REQ-027 On STOP: ptr := SIG_BEGIN[31:2]<<2, end := SIG_END[31:2]<<2 (both latched); if ptr >= end, go directly to DONE with no words emitted.
REQ-028 In DUMP, each cycle: mem_adr_o = (ptr - MEMORY_BASE_ADDRESS)>>2, sig_valid_o=1, sig_data_o = mem_dat_i, ptr += 4; go to DONE when ptr+4 >= end.
REQ-029 Word outside [MEMORY_BASE_ADDRESS, MEMORY_BASE_ADDRESS+MEMORY_SIZE): emit 32'h0, set oob, continue.
REQ-030 Words emitted = (end - begin)/4, ascending, one per cycle, first word the cycle after the STOP ack.
REQ-031 Register writes during DUMP/DONE are stored but do not affect the latched dump.
REQ-032 sig_valid_o=0 and sig_data_o=0 outside DUMP; done_o=1 only in DONE.

Reset
REQ-033 rst_i asserted SHALL immediately clear ack_o, halt_o, done_o, sig_valid_o, oob, SIG_BEGIN, SIG_END, ptr, end, and force IDLE, including mid-dump.
REQ-034 mem_adr_o and sig_data_o SHALL be 0 during reset.

Structure
REQ-035 Register offsets, STATUS bit positions and FSM state encoding SHALL live in a shared package (wb_control_pkg).
REQ-036 The register decode/Wishbone slave and the dump sequencer SHALL be one module; no sub-module required.

Verification
REQ-037 Write SIG_BEGIN=0x2000_0010, SIG_END=0x2000_0020, RAM words 4..7 = 1,2,3,4; write STOP -> sig_valid_o 4 consecutive cycles, data 1,2,3,4; then done_o=1, halt_o=1.
REQ-038 Read offset 0 after writing 0xAABBCCDD with sel_i=4'b0101 onto 0 -> reads 0x00BB00DD; ack exactly one cycle after stb.
REQ-039 SIG_BEGIN=SIG_END=0x2000_0000, write STOP -> no sig_valid_o, done_o=1 next cycle.
REQ-040 SIG_BEGIN=0x2000_3FFC, SIG_END=0x2000_4004 -> words RAM[0xFFF], then 0; STATUS reads 0x7.
REQ-041 Access 0x2000_0000 -> no ack_o, dat_o high-Z; rst_i asserted mid-dump -> sig_valid_o/halt_o drop immediately, STATUS reads 0 after release.
